// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver feeding a 4-byte command parser
// (header, command, data, checksum) that drives the scope's capture-control
// registers.
// Optional build macro: UART_RX_PARITY_EN adds an even-parity bit after the
// data bits, making 11-bit frames.
module uart_cmd_rx #(
  parameter int         CLK_FREQ = 50000000,
  parameter int         BAUD     = 9600,
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter int         GAP_BITS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [1:0] gather_set,
  output logic [7:0] trig_level,
  output logic [7:0] decim,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       cmd_valid,
  output logic       cmd_err,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int GAP_LIMIT    = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W        = $clog2(GAP_LIMIT + 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_HI
  } rx_state_t;

  typedef enum logic [1:0] {P_HDR, P_CMD, P_DATA, P_SUM} p_state_t;

  logic             rx_meta_q, rxs_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_byte_valid_q, rx_byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             bit_end;
  logic             par_bad;

  p_state_t         p_state_q, p_state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       gather_set_q, gather_set_d;
  logic [7:0]       trig_level_q, trig_level_d;
  logic [7:0]       decim_q, decim_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_err_q, cmd_err_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_bad = par_err_q;
`else
  assign par_bad = 1'b0;
`endif

  assign bit_end = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // Receive FSM next-state: start detect, centre sampling, stop/parity check
  always_comb begin
    rx_state_d      = rx_state_q;
    clk_cnt_d       = clk_cnt_q + CNT_W'(1);
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    rx_byte_d       = rx_byte_q;
    rx_byte_valid_d = 1'b0;
    frame_err_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d       = par_err_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (!rxs_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (clk_cnt_q == CNT_W'(HALF_BIT - 1)) begin
          clk_cnt_d  = '0;
          rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (bit_end) begin
          clk_cnt_d  = '0;
          par_err_d  = rxs_q ^ (^shift_q);
          rx_state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT_HI;
          end else if (par_bad) begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_IDLE;
          end else begin
            rx_byte_d       = shift_q;
            rx_byte_valid_d = 1'b1;
            rx_state_d      = RX_IDLE;
          end
        end
      end
      RX_WAIT_HI: begin
        clk_cnt_d = '0;
        if (rxs_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receive FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q      <= RX_IDLE;
      clk_cnt_q       <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      rx_byte_q       <= '0;
      rx_byte_valid_q <= 1'b0;
      frame_err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q       <= 1'b0;
`endif
    end else begin
      rx_state_q      <= rx_state_d;
      clk_cnt_q       <= clk_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      frame_err_q     <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_err_q       <= par_err_d;
`endif
    end
  end

  // Parser next-state: frame assembly, checksum, command apply, gap abort
  always_comb begin
    p_state_d    = p_state_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    gather_set_d = gather_set_q;
    trig_level_d = trig_level_q;
    decim_d      = decim_q;
    cmd_valid_d  = 1'b0;
    cmd_err_d    = 1'b0;
    if (rx_byte_valid_q) begin
      gap_cnt_d = '0;
    end else if (gap_cnt_q != GAP_W'(GAP_LIMIT)) begin
      gap_cnt_d = gap_cnt_q + GAP_W'(1);
    end else begin
      gap_cnt_d = gap_cnt_q;
    end
    if (frame_err_q || (p_state_q != P_HDR && gap_cnt_q == GAP_W'(GAP_LIMIT))) begin
      p_state_d = P_HDR;
    end else if (rx_byte_valid_q) begin
      case (p_state_q)
        P_HDR:  if (rx_byte_q == HDR_BYTE) p_state_d = P_CMD;
        P_CMD: begin
          cmd_d     = rx_byte_q;
          p_state_d = P_DATA;
        end
        P_DATA: begin
          data_d    = rx_byte_q;
          p_state_d = P_SUM;
        end
        P_SUM: begin
          p_state_d = P_HDR;
          if (rx_byte_q == (cmd_q ^ data_q)) begin
            case (cmd_q)
              8'h01: begin
                gather_set_d = data_q[1:0];
                cmd_valid_d  = 1'b1;
              end
              8'h02: begin
                trig_level_d = data_q;
                cmd_valid_d  = 1'b1;
              end
              8'h03: begin
                decim_d     = (data_q == 8'd0) ? 8'd1 : data_q;
                cmd_valid_d = 1'b1;
              end
              default: cmd_err_d = 1'b1;
            endcase
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: p_state_d = P_HDR;
      endcase
    end
  end

  // Parser and control-register state
  always_ff @(posedge clk) begin
    if (rst) begin
      p_state_q    <= P_HDR;
      cmd_q        <= '0;
      data_q       <= '0;
      gather_set_q <= 2'b00;
      trig_level_q <= 8'h80;
      decim_q      <= 8'd1;
      cmd_valid_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      p_state_q    <= p_state_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      gather_set_q <= gather_set_d;
      trig_level_q <= trig_level_d;
      decim_q      <= decim_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_err_q    <= cmd_err_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign gather_set    = gather_set_q;
  assign trig_level    = trig_level_q;
  assign decim         = decim_q;
  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_byte_valid_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_err       = cmd_err_q;
  assign frame_err     = frame_err_q;

endmodule
